// File: rtl/axil_regtest_pkg.sv
// Shared types and the test-pattern generator for the AXI4-Lite register test master.
package axil_regtest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WB,
    ST_RA,
    ST_RD,
    ST_CMP,
    ST_FIN
  } state_e;

  typedef enum logic [1:0] {
    MODE_INC  = 2'd0,
    MODE_WALK = 2'd1,
    MODE_INV  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Patterns are built at the widest supported data width and truncated by the caller.
  localparam int unsigned PATTERN_MAX_W = 64;

  function automatic logic [PATTERN_MAX_W-1:0] pattern(
    input mode_e                    mode,
    input logic [PATTERN_MAX_W-1:0] seed,
    input int unsigned              i,
    input int unsigned              width
  );
    logic [PATTERN_MAX_W-1:0] sum;
    sum = seed + PATTERN_MAX_W'(i);
    case (mode)
      MODE_WALK: pattern = PATTERN_MAX_W'(1) << (i % width);
      MODE_INV:  pattern = ~sum;
      default:   pattern = sum;
    endcase
  endfunction

endpackage

// File: rtl/axil_regtest_timeout.sv
// Per-phase watchdog: counts enabled cycles since the last clear and flags the last allowed one.
module axil_regtest_timeout #(
  parameter int unsigned CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] count;

  assign expired = enable && (count == CW'(CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/axil_regtest_master.sv
// AXI4-Lite master running a write-then-readback test over NUM_REGS registers,
// counting response and compare errors and reporting pass/timeout status.
module axil_regtest_master
  import axil_regtest_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter int unsigned            NUM_REGS       = 4,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
  parameter logic [ADDR_WIDTH-1:0]  ADDR_STRIDE    = ADDR_WIDTH'(4),
  parameter int unsigned            TIMEOUT_CYCLES = 256,
  localparam int unsigned           IDX_W          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [DATA_WIDTH-1:0]     seed,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [15:0]               err_count,
  output logic [IDX_W-1:0]          first_err_idx,

  output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  state_e                 state, state_next;
  mode_e                  mode_q;
  logic [DATA_WIDTH-1:0]  seed_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [IDX_W-1:0]       idx;
  logic                   aw_done, w_done;
  logic                   aw_hs, w_hs, wr_complete, last;
  logic                   phase_clear, phase_en, phase_expired;
  logic                   tmo_evt, bresp_err, rresp_err, cmp_err, err_evt;

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_AWPROT = '0;
  assign M_AXI_ARPROT = '0;
  assign M_AXI_WSTRB  = '1;

  assign aw_hs       = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs        = M_AXI_WVALID && M_AXI_WREADY;
  assign wr_complete = (aw_done || aw_hs) && (w_done || w_hs);
  assign last        = (32'(idx) == NUM_REGS - 1);

  assign phase_en    = (state == ST_WR) || (state == ST_WB) || (state == ST_RA) || (state == ST_RD);
  assign phase_clear = (state_next != state);

  axil_regtest_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (ACLK),
    .rst     (ARESET),
    .clear   (phase_clear),
    .enable  (phase_en),
    .expired (phase_expired)
  );

  // A handshake completing in the watchdog's final cycle still wins, so the
  // slave is never left with an accepted request that nobody will retire.
  assign tmo_evt   = phase_en && (state_next == ST_FIN);
  assign bresp_err = (state == ST_WB) && M_AXI_BVALID && (M_AXI_BRESP != RESP_OKAY);
  assign rresp_err = (state == ST_RD) && M_AXI_RVALID && (M_AXI_RRESP != RESP_OKAY);
  assign cmp_err   = (state == ST_CMP) && (rdata_q != wdata_q);
  assign err_evt   = tmo_evt || bresp_err || rresp_err || cmp_err;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_WR;
      ST_WR: begin
        if (wr_complete)        state_next = ST_WB;
        else if (phase_expired) state_next = ST_FIN;
      end
      ST_WB: begin
        if (M_AXI_BVALID)       state_next = ST_RA;
        else if (phase_expired) state_next = ST_FIN;
      end
      ST_RA: begin
        if (M_AXI_ARREADY)      state_next = ST_RD;
        else if (phase_expired) state_next = ST_FIN;
      end
      ST_RD: begin
        if (M_AXI_RVALID)       state_next = ST_CMP;
        else if (phase_expired) state_next = ST_FIN;
      end
      ST_CMP:  state_next = last ? ST_FIN : ST_WR;
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    unique case (state)
      ST_WR: begin
        M_AXI_AWVALID = !aw_done;
        M_AXI_WVALID  = !w_done;
        busy          = 1'b1;
      end
      ST_WB: begin
        M_AXI_BREADY = 1'b1;
        busy         = 1'b1;
      end
      ST_RA: begin
        M_AXI_ARVALID = 1'b1;
        busy          = 1'b1;
      end
      ST_RD: begin
        M_AXI_RREADY = 1'b1;
        busy         = 1'b1;
      end
      ST_CMP:  busy = 1'b1;
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      mode_q        <= MODE_INC;
      seed_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      addr_q        <= '0;
      idx           <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      timeout       <= 1'b0;
      pass          <= 1'b0;
    end else begin
      aw_done <= (state == ST_WR) && (state_next == ST_WR) && (aw_done || aw_hs);
      w_done  <= (state == ST_WR) && (state_next == ST_WR) && (w_done || w_hs);

      if (state == ST_RD && M_AXI_RVALID) rdata_q <= M_AXI_RDATA;
      if (tmo_evt) timeout <= 1'b1;

      if (err_evt) begin
        if (err_count != '1) err_count <= err_count + 16'd1;
        if (err_count == '0) first_err_idx <= idx;
      end

      if (state == ST_CMP && !last) begin
        idx     <= idx + 1'b1;
        addr_q  <= addr_q + ADDR_STRIDE;
        wdata_q <= DATA_WIDTH'(pattern(mode_q, PATTERN_MAX_W'(seed_q), 32'(idx) + 32'd1, DATA_WIDTH));
      end

      if (state == ST_FIN) pass <= (err_count == '0) && !timeout;

      if (state == ST_IDLE && start) begin
        mode_q        <= mode_e'(mode);
        seed_q        <= seed;
        idx           <= '0;
        addr_q        <= BASE_ADDR;
        wdata_q       <= DATA_WIDTH'(pattern(mode_e'(mode), PATTERN_MAX_W'(seed), 32'd0, DATA_WIDTH));
        err_count     <= '0;
        first_err_idx <= '0;
        timeout       <= 1'b0;
        pass          <= 1'b0;
      end
    end
  end

endmodule

// File: doc/axil_regtest_master.md
# axil_regtest_master

Synthesizable AXI4-Lite master that runs a parametrised write-then-readback register test: it writes a generated pattern to each of NUM_REGS registers at BASE_ADDR + i*ADDR_STRIDE, reads each one back, compares the data, and counts failures. It is the in-fabric, parametrised successor to the BFM-driven register write/read test. It sits in the block design in place of the master BFM and drives the slave under test directly. Results are exposed as status ports for a PS register or ILA.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width; multiple of 8
- NUM_REGS, 4, registers tested per pass; ≥1
- BASE_ADDR, 0, address of register 0
- ADDR_STRIDE, 4, byte step between registers
- TIMEOUT_CYCLES, 256, maximum wait per channel phase before abort
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- mode  in  2  pattern: 0 = seed+i, 1 = walking one (1<<(i mod DATA_WIDTH)), 2 = ~(seed+i), 3 = reserved (treated as 0)
- seed  in  DATA_WIDTH  pattern seed, sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of test
- pass  out  1  valid after done; 1 if err_count==0 and no timeout; held until next start
- timeout  out  1  sticky; set on any phase exceeding TIMEOUT_CYCLES
- err_count  out  16  mismatches plus non-OKAY responses; saturates at 0xFFFF
- first_err_idx  out  clog2(NUM_REGS) (min 1)  index of first failing register
- M_AXI_AW*/W*/B*/AR*/R*  standard AXI4-Lite master channels; AWPROT/ARPROT = 0; WSTRB all ones

## Operation
- The FSM has states IDLE, WR, WB, RA, RD, CMP, FIN.
- IDLE: on start, latch seed and mode (mode is sampled only here), clear err_count, first_err_idx, timeout, and pass, set i=0, go to WR.
- WR: AWVALID and WVALID rise in the same cycle. Each is dropped independently on its own handshake. When both have completed, go to WB.
- WB: BREADY=1. On BVALID, a BRESP other than OKAY increments err_count. Go to RA.
- RA: ARVALID=1 until ARREADY, then go to RD.
- RD: RREADY=1. On RVALID, capture RDATA. An RRESP other than OKAY increments err_count. Go to CMP.
- CMP: if RDATA ≠ expected, increment err_count. Record first_err_idx on the first error, whether it is a response error or a compare error. If i==NUM_REGS-1, go to FIN; otherwise i++ and go to WR.
- FIN: pulse done, compute pass, return to IDLE.
- Address for register i: BASE_ADDR + i*ADDR_STRIDE, computed modulo 2^ADDR_WIDTH (wrap-around is allowed).
- Pattern arithmetic is modulo 2^DATA_WIDTH.
- Timeout: a phase counter resets on every state entry. If it reaches TIMEOUT_CYCLES, set timeout, increment err_count, drop all VALID/READY, and go to FIN.
- A start pulse while busy is ignored.
- On ARESET (asserted at any time, including mid-transaction):
  - All outputs go to 0 immediately: VALIDs, READYs, busy, done, pass, timeout, err_count, first_err_idx, addresses, data.
  - The FSM goes to IDLE. No attempt is made to finish the outstanding transaction.

## Timing
- Zero-wait slave (READY held high, response the cycle after the handshake): each register takes exactly 5 cycles (WR, WB, RA, RD, CMP).
- Start-to-done latency for such a slave is 5*NUM_REGS+1 cycles; done is asserted in that cycle.
- AW and W may complete in different cycles. A VALID is never dropped before its handshake.
- Only one transaction is outstanding at a time; no read is issued before its write response.
- busy rises in the cycle after start and falls in the cycle done is asserted.

## Structure
- Package axil_regtest_pkg holds:
  - the state enum;
  - the mode encodings;
  - RESP_OKAY=2'b00;
  - the function pattern(mode, seed, i).
- Sub-module axil_regtest_timeout: a phase watchdog counter with inputs clear/enable and output expired.

## Test plan
- Default parameters, AXI-Lite register slave, seed 0x0101FFFF, mode 0 -> writes 0x0101FFFF, 0x01020000, 0x01020001, 0x01020002 at addresses 0x0, 0x4, 0x8, 0xC. Readback matches; pass=1, err_count=0, done 21 cycles after start.
- Mode 1, NUM_REGS=4 -> data 0x1, 0x2, 0x4, 0x8. Mode 2 with seed 0 -> 0xFFFFFFFF, 0xFFFFFFFE, 0xFFFFFFFD, 0xFFFFFFFC. pass=1 in both cases.
- Slave with bit 0 of register 2 stuck at 0, mode 0, seed 0xDEAD0011 -> err_count=1, first_err_idx=2, pass=0.
- Slave returns SLVERR on the write response for register 1 only -> err_count=1, first_err_idx=1, pass=0.
- Slave never asserts ARREADY, TIMEOUT_CYCLES=16 -> timeout=1, done pulses 16 cycles after RA is entered, ARVALID drops, pass=0.
- ARESET pulsed while WB is waiting -> all outputs 0 immediately. A fresh start afterwards completes with pass=1. A start pulsed while busy has no effect.
